kbd_scan_fifo: RTL and testbench
================================

Name: kbd_scan_fifo

Overview:
- Sits between the PS/2 keyboard bit deserializer and the DMA input port in3.
- Takes raw scan-code bytes, folds the E0 (extended) and F0 (break) prefix bytes into flags, and queues complete key events in a FIFO.
- Presents the head event as a 32-bit status/data word for the CPU.
- Raises an interrupt pulse per queued event; the CPU drains events with a pop strobe.

Parameters:
- DEPTH, 8, FIFO entries. Must be a power of two, 2..16.
- AW, 3, pointer width. Must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; the block uses this single clock only.
- rst  in  1  reset, synchronous and active-high.
- rx_data  in  8  byte from the PS/2 deserializer.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- pop  in  1  one-cycle strobe from the CPU/DMA side; removes the head entry.
- out  out  32  event word for DMA in3. Layout:
  - [7:0] code
  - [8] break
  - [9] extended
  - [11:10] zero
  - [15:12] fill count, zero-extended
  - [16] nonempty
  - [17] overflow (sticky)
  - [31:18] zero
- irq  out  1  one-cycle pulse for each event accepted into the FIFO.

Behaviour:
- Reset: synchronous, active-high. Takes effect on the clk edge where rst=1 and overrides every other input that cycle.
  - Flushes the FIFO: pointers=0, count=0.
  - Prefix FSM goes to IDLE.
  - out=32'h0, irq=0, overflow=0.
  - Reset mid-sequence discards any pending prefix; reset while full discards all entries.
- Prefix FSM states: IDLE, E0, F0, E0F0. Transitions, taken only on rx_valid:
  - IDLE: byte E0 -> E0; byte F0 -> F0; any other byte -> push {ext=0, brk=0, code}, stay IDLE.
  - E0: byte F0 -> E0F0; byte E0 -> stay E0; other -> push {ext=1, brk=0, code} -> IDLE.
  - F0: byte E0 -> E0 (protocol restart; the break prefix is dropped); byte F0 -> stay F0; other -> push {0, 1, code} -> IDLE.
  - E0F0: bytes E0 or F0 -> stay E0F0; other -> push {1, 1, code} -> IDLE.
  - Bytes E1, AA, FA, FE, 00, FF are ordinary codes and are pushed.
- FIFO entry: 10 bits {ext, brk, code}. Storage is a register array; write pointer and read pointer are AW bits wide; count is AW+1 bits.
- Push attempt in the same cycle as the final rx_valid byte:
  - Not full, or full with pop in the same cycle: the entry is written, wptr+1 (wraps modulo DEPTH), and irq=1 on the next cycle for exactly one cycle.
  - Full without pop: the entry is dropped, overflow is set, and irq is not pulsed.
- Pop:
  - Nonempty: rptr+1 (wraps), count-1.
  - Empty: ignored, with no pointer change.
  - Pop also clears overflow, except when an overflow occurs in the same cycle, in which case overflow stays set.
- Simultaneous push and pop:
  - Nonempty: both happen and count is unchanged.
  - Empty: the pop is ignored and the push happens (count becomes 1).
- out is a registered output updated every cycle from the post-update state. Latency: event byte strobe -> out nonempty/code visible 1 cycle later. With count=0, out[9:0] = 0.
- irq is registered: it is asserted in the cycle after the accepting clock edge.
- Count never exceeds DEPTH. Fill count for DEPTH=16 saturates the 4-bit field as 4'hF only when count=16; implement as min(count, 15).

Test Plan:
- Byte 1C alone -> one cycle later out=32'h0001_101C, irq pulses for 1 cycle.
- Sequence E0,F0,75 into an empty FIFO -> out=32'h0001_1375; irq pulses only after the 75 byte.
- Sequence F0,E0,74 -> out=32'h0001_1274 (the break prefix is dropped, the extended prefix is kept).
- 9 plain codes 01..09 with no pop (DEPTH=8):
  - out[15:12]=8 and out[17]=1.
  - Head code stays 01; no irq on the ninth byte.
  - Then pop 8 times -> codes 02..08 appear in order, and out returns to 32'h0 (overflow was cleared by the first pop).
- FIFO holding 1 entry, rx byte 2A and pop in the same cycle -> count stays 1 and out[7:0]=2A next cycle. Pop on an empty FIFO -> out stays 0.
- rst asserted in state E0 with 3 entries queued, then byte 11 -> out=32'h0001_1011 (non-extended), count=1.

Source files
------------

// File: rtl/kbd_scan_fifo.sv
// kbd_scan_fifo
// Folds PS/2 scan-code prefix bytes (E0 = extended, F0 = break) into flags
// and queues complete key events in a small FIFO for the CPU/DMA side.
//
// Ports:
//   clk       system clock (single clock domain)
//   rst       synchronous, active-high reset
//   rx_data   byte from the PS/2 deserializer
//   rx_valid  one-cycle strobe qualifying rx_data
//   pop       one-cycle strobe removing the head event
//   out       event word: [7:0] code, [8] break, [9] extended,
//             [15:12] fill count, [16] nonempty, [17] sticky overflow
//   irq       one-cycle pulse per event accepted into the FIFO
module kbd_scan_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        pop,
    output logic [31:0] out,
    output logic        irq
);

    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0
    } state_t;

    state_t        state;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          is_e0;
    logic          is_f0;
    logic          push_req;
    logic [9:0]    new_entry;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;
    logic          ovf_evt;
    logic [AW-1:0] wptr_n;
    logic [AW-1:0] rptr_n;
    logic [CW-1:0] count_n;
    logic          overflow_n;
    logic [9:0]    head_n;
    logic [4:0]    count_ext;
    logic [3:0]    fill_n;

    always_comb begin
        is_e0      = (rx_data == 8'hE0);
        is_f0      = (rx_data == 8'hF0);
        // Any byte that is not a prefix completes an event, whatever the state.
        push_req   = rx_valid && !is_e0 && !is_f0;
        new_entry  = {(state == ST_E0) || (state == ST_E0F0),
                      (state == ST_F0) || (state == ST_E0F0),
                      rx_data};
        full       = (count == CW'(DEPTH));
        empty      = (count == '0);
        do_pop     = pop && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push    = push_req && (!full || pop);
        ovf_evt    = push_req && full && !pop;

        wptr_n     = do_push ? wptr + AW'(1) : wptr;
        rptr_n     = do_pop  ? rptr + AW'(1) : rptr;
        count_n    = count;
        if (do_push && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CW'(1);
        end

        overflow_n = overflow;
        if (ovf_evt) begin
            overflow_n = 1'b1;
        end else if (pop) begin
            overflow_n = 1'b0;
        end

        // When the new entry lands in the slot that becomes the head, it is
        // not in the array yet, so forward it directly.
        if (do_push && (wptr == rptr_n)) begin
            head_n = new_entry;
        end else begin
            head_n = mem[rptr_n];
        end

        count_ext = 5'(count_n);
        fill_n    = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
    end

    // Entry storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wptr] <= new_entry;
        end
    end

    // Prefix FSM, pointers, flags and the registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            out      <= 32'h0;
            irq      <= 1'b0;
        end else begin
            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (is_e0)      state <= ST_E0;
                        else if (is_f0) state <= ST_F0;
                        else            state <= ST_IDLE;
                    end
                    ST_E0: begin
                        if (is_f0)      state <= ST_E0F0;
                        else if (is_e0) state <= ST_E0;
                        else            state <= ST_IDLE;
                    end
                    ST_F0: begin
                        // E0 after F0 restarts the sequence; the break is dropped.
                        if (is_e0)      state <= ST_E0;
                        else if (is_f0) state <= ST_F0;
                        else            state <= ST_IDLE;
                    end
                    default: begin
                        if (is_e0 || is_f0) state <= ST_E0F0;
                        else                state <= ST_IDLE;
                    end
                endcase
            end
            wptr     <= wptr_n;
            rptr     <= rptr_n;
            count    <= count_n;
            overflow <= overflow_n;
            irq      <= do_push;
            out      <= {14'b0, overflow_n, (count_n != '0), fill_n, 2'b00,
                         (count_n != '0) ? head_n : 10'b0};
        end
    end

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// tb_kbd_scan_fifo
// Self-checking bench for kbd_scan_fifo: directed scenarios with known
// event words plus a randomized run against a queue-based reference model.
module tb_kbd_scan_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        pop;
    logic [31:0] out;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a queue of {ext, brk, code} events plus pending
    // prefix flags and the sticky overflow bit.
    logic [9:0] mq[$];
    bit         m_ext;
    bit         m_brk;
    bit         m_ovf;
    bit         m_irq;

    kbd_scan_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pop      (pop),
        .out      (out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_out();
        logic [31:0] w;
        int n;
        w = 32'h0;
        n = mq.size();
        if (n > 0) begin
            w[9:0] = mq[0];
            w[16]  = 1'b1;
        end
        w[15:12] = (n > 15) ? 4'hF : 4'(n);
        w[17]    = m_ovf;
        return w;
    endfunction

    // Drives one clock cycle of inputs and advances the model; returns #1
    // after the edge so outputs can be sampled.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic p);
        logic       push_req;
        logic [9:0] entry;
        bit         ovf_now;
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        pop      = p;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ext = 0;
            m_brk = 0;
            m_ovf = 0;
            m_irq = 0;
        end else begin
            push_req = v && (d != 8'hE0) && (d != 8'hF0);
            entry    = {m_ext, m_brk, d};
            ovf_now  = push_req && (mq.size() == DEPTH) && !p;
            if (p && mq.size() > 0) void'(mq.pop_front());
            m_irq = 0;
            if (push_req && !ovf_now) begin
                mq.push_back(entry);
                m_irq = 1;
            end
            if (ovf_now) m_ovf = 1;
            else if (p)  m_ovf = 0;
            if (v) begin
                if (d == 8'hE0) begin
                    if (m_brk && !m_ext) m_brk = 0;
                    m_ext = 1;
                end else if (d == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    m_ext = 0;
                    m_brk = 0;
                end
            end
        end
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pop      = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic pop_one();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 8'h1C, 1'b1);
        do_reset();
        tests_run++;
        if (out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out got %h want %h", out, 32'h0);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq got %b want 0", irq);
        end
    endtask

    task automatic test_single_code();
        do_reset();
        send(8'h1C);
        tests_run++;
        if (out !== 32'h0001_101C) begin
            tests_failed++;
            $display("[TB] FAIL single_out got %h want %h", out, 32'h0001_101C);
        end
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_irq got %b want 1", irq);
        end
        idle();
        tests_run++;
        if (irq !== 1'b0 || out !== 32'h0001_101C) begin
            tests_failed++;
            $display("[TB] FAIL single_hold irq=%b out=%h want irq=0 out=%h", irq, out, 32'h0001_101C);
        end
    endtask

    task automatic test_ext_break();
        do_reset();
        send(8'hE0);
        tests_run++;
        if (irq !== 1'b0 || out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL extbrk_after_e0 irq=%b out=%h want irq=0 out=0", irq, out);
        end
        send(8'hF0);
        tests_run++;
        if (irq !== 1'b0 || out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL extbrk_after_f0 irq=%b out=%h want irq=0 out=0", irq, out);
        end
        send(8'h75);
        tests_run++;
        if (irq !== 1'b1 || out !== 32'h0001_1375) begin
            tests_failed++;
            $display("[TB] FAIL extbrk_event irq=%b out=%h want irq=1 out=%h", irq, out, 32'h0001_1375);
        end
    endtask

    task automatic test_break_restart();
        do_reset();
        send(8'hF0);
        send(8'hE0);
        send(8'h74);
        tests_run++;
        if (irq !== 1'b1 || out !== 32'h0001_1274) begin
            tests_failed++;
            $display("[TB] FAIL restart_event irq=%b out=%h want irq=1 out=%h", irq, out, 32'h0001_1274);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'(i));
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ovf_eighth_irq got %b want 1", irq);
        end
        send(8'h09);
        tests_run++;
        if (irq !== 1'b0 || out !== 32'h0003_8001) begin
            tests_failed++;
            $display("[TB] FAIL ovf_ninth irq=%b out=%h want irq=0 out=%h", irq, out, 32'h0003_8001);
        end
        for (int i = 1; i <= 8; i++) begin
            pop_one();
            if (i == 8) exp = 32'h0;
            else        exp = {14'b0, 1'b0, 1'b1, 4'(8 - i), 2'b00, 2'b00, 8'(i + 1)};
            tests_run++;
            if (out !== exp) begin
                tests_failed++;
                $display("[TB] FAIL ovf_drain%0d got %h want %h", i, out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(8'h55);
        cycle(1'b0, 1'b1, 8'h2A, 1'b1);
        tests_run++;
        if (irq !== 1'b1 || out !== 32'h0001_102A) begin
            tests_failed++;
            $display("[TB] FAIL pushpop irq=%b out=%h want irq=1 out=%h", irq, out, 32'h0001_102A);
        end
        pop_one();
        tests_run++;
        if (out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL pushpop_drain got %h want 0", out);
        end
        pop_one();
        tests_run++;
        if (out !== 32'h0 || irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pop_empty out=%h irq=%b want out=0 irq=0", out, irq);
        end
        // Push into an empty FIFO with a simultaneous (ignored) pop.
        cycle(1'b0, 1'b1, 8'h3B, 1'b1);
        tests_run++;
        if (out !== 32'h0001_103B || irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL empty_pushpop out=%h irq=%b want out=%h irq=1", out, irq, 32'h0001_103B);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h21);
        send(8'h22);
        send(8'h23);
        send(8'hE0);
        tests_run++;
        if (out !== 32'h0001_3021) begin
            tests_failed++;
            $display("[TB] FAIL midrst_pre got %h want %h", out, 32'h0001_3021);
        end
        do_reset();
        tests_run++;
        if (out !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_flush got %h want 0", out);
        end
        send(8'h11);
        tests_run++;
        if (out !== 32'h0001_1011 || irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_event out=%h irq=%b want out=%h irq=1", out, irq, 32'h0001_1011);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       v;
        logic       p;
        logic [7:0] d;
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 5))
                0:       d = 8'hE0;
                1:       d = 8'hF0;
                default: d = 8'($urandom_range(0, 255));
            endcase
            if (i < 1500) p = ($urandom_range(0, 9) < 2);
            else          p = ($urandom_range(0, 9) < 5);
            cycle(r, v, d, p);
            exp = model_out();
            tests_run++;
            if (out !== exp || irq !== m_irq) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d out=%h irq=%b want out=%h irq=%b", i, out, irq, exp, m_irq);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pop      = 1'b0;
        test_reset();
        test_single_code();
        test_ext_break();
        test_break_restart();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
